// File: rtl/alu_share_arbiter_if.sv
// Purpose : bundles the two requester ports, the two response ports and the shared-ALU port of alu_share_arbiter.
// Latency : wiring only.
// Backpressure: carries req*_valid/ready and rsp*_valid/ready handshakes; the arbiter's behaviour is described in alu_share_arbiter.sv.
// Ports   : slave modport is the arbiter's view; master modport is the view of the requesters and the ALU.
interface alu_share_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    // requester 0 / 1 operation request
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [CTRL_W-1:0] req0_ctrl;
    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [CTRL_W-1:0] req1_ctrl;

    // response to requester 0 / 1
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [WIDTH-1:0]  rsp0_rslt;
    logic              rsp0_zero;
    logic              rsp0_err;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [WIDTH-1:0]  rsp1_rslt;
    logic              rsp1_zero;
    logic              rsp1_err;

    // shared combinational ALU
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [WIDTH-1:0]  alu_rslt;
    logic              alu_zero;

    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rslt, rsp0_zero, rsp0_err,
        output rsp1_valid, rsp1_rslt, rsp1_zero, rsp1_err,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_rslt, alu_zero,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rslt, rsp0_zero, rsp0_err,
        input  rsp1_valid, rsp1_rslt, rsp1_zero, rsp1_err,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_rslt, alu_zero,
        input  busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin share of one combinational ALU between two requesters, registered operands and result.
// Latency : accept at edge k, result captured at edge k+1, response valid from then on; 1 op per 3 cycles peak.
// Backpressure: requests are refused (ready=0) outside IDLE; the response is held until the owner's rsp ready.
// Ports   : clk, rst_n (async active-low); bus = alu_share_arbiter_if.slave carrying req0/req1, rsp0/rsp1,
//           the ALU operand/result port and busy.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              prio_q,  prio_d;
    logic [WIDTH-1:0]  a_q,     a_d;
    logic [WIDTH-1:0]  b_q,     b_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [WIDTH-1:0]  rslt_q,  rslt_d;
    logic              zero_q,  zero_d;
    logic              err_q,   err_d;

    logic grant;
    logic idle;
    logic accept;
    logic rsp_ack;

    // Codes the ALU implements; anything else still goes through the ALU
    // but is reported back with err set.
    function automatic logic ctrl_unsupported(input logic [CTRL_W-1:0] c);
        logic unsup;
        unsup = 1'b1;
        if (c == CTRL_W'(4'b0000) || c == CTRL_W'(4'b0001) ||
            c == CTRL_W'(4'b0010) || c == CTRL_W'(4'b0100) ||
            c == CTRL_W'(4'b1001) || c == CTRL_W'(4'b1010)) begin
            unsup = 1'b0;
        end
        return unsup;
    endfunction

    // Grant: a lone requester always wins; on a tie prio_q picks the winner.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = prio_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    assign idle           = (state_q == S_IDLE);
    assign bus.req0_ready = idle && bus.req0_valid && !grant;
    assign bus.req1_ready = idle && bus.req1_valid &&  grant;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign rsp_ack        = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        rslt_d  = rslt_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                    owner_d = grant;
                    a_d     = grant ? bus.req1_a    : bus.req0_a;
                    b_d     = grant ? bus.req1_b    : bus.req0_b;
                    ctrl_d  = grant ? bus.req1_ctrl : bus.req0_ctrl;
                end
            end
            S_EXEC: begin
                // Operands have been stable on the ALU for the whole cycle.
                state_d = S_RESP;
                rslt_d  = bus.alu_rslt;
                zero_d  = bus.alu_zero;
                err_d   = ctrl_unsupported(ctrl_q);
            end
            S_RESP: begin
                if (rsp_ack) begin
                    state_d = S_IDLE;
                    // The requester just served loses the next tie.
                    prio_d  = ~owner_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            rslt_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            rslt_q  <= rslt_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    // ALU is driven straight from flops so its inputs never glitch.
    assign bus.alu_a    = a_q;
    assign bus.alu_b    = b_q;
    assign bus.alu_ctrl = ctrl_q;

    // Result registers are shown on both ports; only the owner's valid rises.
    assign bus.rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign bus.rsp1_valid = (state_q == S_RESP) &&  owner_q;
    assign bus.rsp0_rslt  = rslt_q;
    assign bus.rsp1_rslt  = rslt_q;
    assign bus.rsp0_zero  = zero_q;
    assign bus.rsp1_zero  = zero_q;
    assign bus.rsp0_err   = err_q;
    assign bus.rsp1_err   = err_q;

    assign bus.busy = !idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(4)) bus ();

    alu_share_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {zero, rslt}. Unimplemented codes give 0.
    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        logic [31:0] r;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0100: r = a - b;
            4'b1001: r = a << b[4:0];
            4'b1010: r = a >> b[4:0];
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    function automatic logic is_supported(input logic [3:0] c);
        return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b1010};
    endfunction

    // The ALU the arbiter shares.
    always_comb begin
        logic [32:0] zr;
        zr = ref_alu(bus.alu_a, bus.alu_b, bus.alu_ctrl);
        bus.alu_rslt = zr[31:0];
        bus.alu_zero = zr[32];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 = free, 1 = operation in the ALU, 2 = response offered
    int          m_phase = 0;
    logic        m_owner = 1'b0;
    logic        m_prio  = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_r = '0;
    logic [3:0]  m_c = '0;
    logic        m_z = 1'b0, m_e = 1'b0;

    function automatic logic model_winner(input logic v0, input logic v1, input logic prio);
        if (v0 && v1) return prio;
        return v1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_owner = 1'b0; m_prio = 1'b0;
            m_a = '0; m_b = '0; m_c = '0; m_r = '0; m_z = 1'b0; m_e = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.req0_valid || bus.req1_valid) begin
                    m_owner = model_winner(bus.req0_valid, bus.req1_valid, m_prio);
                    m_a = m_owner ? bus.req1_a    : bus.req0_a;
                    m_b = m_owner ? bus.req1_b    : bus.req0_b;
                    m_c = m_owner ? bus.req1_ctrl : bus.req0_ctrl;
                    m_phase = 1;
                end
                1: begin
                    logic [32:0] zr;
                    zr = ref_alu(m_a, m_b, m_c);
                    m_r = zr[31:0];
                    m_z = zr[32];
                    m_e = !is_supported(m_c);
                    m_phase = 2;
                end
                default: if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
                    m_phase = 0;
                    m_prio  = !m_owner;
                end
            endcase
        end
    end

    // Compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            logic w;
            w = model_winner(bus.req0_valid, bus.req1_valid, m_prio);
            chk("busy",       32'(bus.busy),       32'(m_phase != 0));
            chk("req0_ready", 32'(bus.req0_ready), 32'(m_phase == 0 && bus.req0_valid && !w));
            chk("req1_ready", 32'(bus.req1_ready), 32'(m_phase == 0 && bus.req1_valid &&  w));
            chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_phase == 2 && !m_owner));
            chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_phase == 2 &&  m_owner));
            if (m_phase == 1) begin
                chk("exec_alu_a",    bus.alu_a,           m_a);
                chk("exec_alu_b",    bus.alu_b,           m_b);
                chk("exec_alu_ctrl", 32'(bus.alu_ctrl),   32'(m_c));
            end
            if (m_phase == 2) begin
                chk("rsp_rslt", m_owner ? bus.rsp1_rslt : bus.rsp0_rslt, m_r);
                chk("rsp_zero", 32'(m_owner ? bus.rsp1_zero : bus.rsp0_zero), 32'(m_z));
                chk("rsp_err",  32'(m_owner ? bus.rsp1_err  : bus.rsp0_err),  32'(m_e));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Present one request and return in the EXEC cycle after its accept.
    // Operands are scrambled after the accept to show they are not re-sampled.
    task automatic issue(input bit idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
        bit done = 0;
        if (idx) begin bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c; bus.req1_valid = 1'b1; end
        else     begin bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c; bus.req0_valid = 1'b1; end
        for (int i = 0; i < 12 && !done; i++) begin
            #1;
            if (idx ? bus.req1_ready : bus.req0_ready) done = 1;
            cyc(1);
        end
        if (!done) fail_now("issue_timeout");
        if (idx) begin bus.req1_valid = 1'b0; bus.req1_a = $urandom; bus.req1_b = $urandom; end
        else     begin bus.req0_valid = 1'b0; bus.req0_a = $urandom; bus.req0_b = $urandom; end
    endtask

    task automatic expect_rsp(input string name, input int port, input logic [31:0] r,
                              input logic z, input logic e);
        bit got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            cyc(1);
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                got = 1;
                chk({name, "_port"}, 32'(bus.rsp1_valid), 32'(port));
                chk({name, "_rslt"}, bus.rsp1_valid ? bus.rsp1_rslt : bus.rsp0_rslt, r);
                chk({name, "_zero"}, 32'(bus.rsp1_valid ? bus.rsp1_zero : bus.rsp0_zero), 32'(z));
                chk({name, "_err"},  32'(bus.rsp1_valid ? bus.rsp1_err  : bus.rsp0_err),  32'(e));
            end
        end
        if (!got) fail_now({name, "_timeout"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_ctrl = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_ctrl = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;

        // Reset values
        do_reset();
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_ctrl",  32'(bus.alu_ctrl), 0);
        chk("rst_rsp0v", 32'(bus.rsp0_valid), 0);
        chk("rst_rsp1v", 32'(bus.rsp1_valid), 0);
        chk("rst_err",   32'(bus.rsp0_err), 0);
        chk("rst_rslt",  bus.rsp0_rslt, 0);

        // Single op with latency: 5 + 7
        bus.req0_a = 5; bus.req0_b = 7; bus.req0_ctrl = 4'b0010; bus.req0_valid = 1;
        #1;
        chk("t1_ready", 32'(bus.req0_ready), 1);
        cyc(1);
        bus.req0_valid = 0;
        chk("t1_exec_busy",  32'(bus.busy), 1);
        chk("t1_exec_rsp0v", 32'(bus.rsp0_valid), 0);
        cyc(1);
        chk("t1_rsp0v", 32'(bus.rsp0_valid), 1);
        chk("t1_rsp1v", 32'(bus.rsp1_valid), 0);
        chk("t1_rslt",  bus.rsp0_rslt, 12);
        chk("t1_zero",  32'(bus.rsp0_zero), 0);
        chk("t1_err",   32'(bus.rsp0_err), 0);
        bus.rsp0_ready = 1;
        cyc(1);
        bus.rsp0_ready = 0;
        chk("t1_idle", 32'(bus.busy), 0);

        // Tie after reset, then round-robin with both held valid
        do_reset();
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        bus.req0_a = 9; bus.req0_b = 9; bus.req0_ctrl = 4'b0100;
        bus.req1_a = 3; bus.req1_b = 4; bus.req1_ctrl = 4'b0001;
        bus.req0_valid = 1; bus.req1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) expect_rsp("rr_req0", 0, 0, 1'b1, 1'b0);
            else            expect_rsp("rr_req1", 1, 7, 1'b0, 1'b0);
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        cyc(3);

        // Back-pressure on rsp1 while req0 waits
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        issue(1, 32'd10, 32'd3, 4'b0000);
        cyc(1);
        bus.req0_a = 20; bus.req0_b = 22; bus.req0_ctrl = 4'b0010; bus.req0_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp1v",   32'(bus.rsp1_valid), 1);
            chk("bp_rslt",    bus.rsp1_rslt, 2);
            chk("bp_req0rdy", 32'(bus.req0_ready), 0);
            cyc(1);
        end
        bus.rsp1_ready = 1;
        cyc(1);
        bus.rsp1_ready = 0;
        #1;
        chk("bp_next_idle", 32'(bus.busy), 0);
        chk("bp_req0rdy_after", 32'(bus.req0_ready), 1);
        cyc(1);
        bus.req0_valid = 0;
        chk("bp_accepted", 32'(bus.busy), 1);
        bus.rsp0_ready = 1;
        expect_rsp("bp_req0", 0, 42, 1'b0, 1'b0);

        // Unsupported code
        bus.rsp1_ready = 1;
        issue(1, 32'hFFFF_FFFF, 32'd1, 4'b1111);
        expect_rsp("unsup", 1, 0, 1'b1, 1'b1);

        // Shift path, operands held during EXEC although inputs changed
        issue(0, 32'd1, 32'd4, 4'b1001);
        #1;
        chk("sh_alu_a",    bus.alu_a, 1);
        chk("sh_alu_b",    bus.alu_b, 4);
        chk("sh_alu_ctrl", 32'(bus.alu_ctrl), 9);
        expect_rsp("shift", 0, 16, 1'b0, 1'b0);

        // Reset during EXEC (prio is 1 here, reset must return it to 0)
        issue(1, 32'd7, 32'd8, 4'b0010);
        #1;
        rst_n = 0;
        #1;
        chk("mr_busy",   32'(bus.busy), 0);
        chk("mr_rsp1v",  32'(bus.rsp1_valid), 0);
        chk("mr_alu_a",  bus.alu_a, 0);
        chk("mr_ctrl",   32'(bus.alu_ctrl), 0);
        cyc(1);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("mr_no_rsp1", 32'(bus.rsp1_valid), 0);
            chk("mr_idle",    32'(bus.busy), 0);
        end
        bus.req0_a = 1; bus.req0_b = 1; bus.req0_ctrl = 4'b0010;
        bus.req1_a = 2; bus.req1_b = 2; bus.req1_ctrl = 4'b0010;
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        chk("mr_tie_req0", 32'(bus.req0_ready), 1);
        chk("mr_tie_req1", 32'(bus.req1_ready), 0);
        cyc(1);
        bus.req0_valid = 0; bus.req1_valid = 0;
        expect_rsp("mr_after", 0, 2, 1'b0, 1'b0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
